// File: rtl/vga_bin_reader_pkg.sv
// +------------------------------------------------------------------+
// | vga_bin_reader_pkg : shared xy_bin geometry, palette and states  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package vga_bin_reader_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int ADDR_W   = 19;
    localparam int BIN_W    = 3;

    // Entry 0 is the rightmost element of the concatenation.
    localparam logic [7:0][11:0] PALETTE = {
        12'hFFF, 12'hF0F, 12'h0FF, 12'hFF0,
        12'h00F, 12'h0F0, 12'hF00, 12'h000
    };

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        STREAM   = 2'd2
    } state_t;

    // v*640 + h without a multiplier: 640 = 512 + 128.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] h, input logic [9:0] v);
        logic [ADDR_W-1:0] vv;
        logic [ADDR_W-1:0] hh;
        vv = ADDR_W'(v);
        hh = ADDR_W'(h);
        return (vv << 9) + (vv << 7) + hh;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_bin_reader_sync_delay_pipe.sv
// +------------------------------------------------------------------+
// | sync_delay_pipe : strobe-gated delay line for hsync/vsync/blank  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module sync_delay_pipe #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else if (en) begin
            pipe_q[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q = pipe_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/vga_bin_reader.sv
// +------------------------------------------------------------------+
// | vga_bin_reader : streams xy_bin BRAM bins to VGA RGB via palette |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module vga_bin_reader
    import vga_bin_reader_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pix_en,
    input  logic              vga_start,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              blank_in,
    input  logic [BIN_W-1:0]  bin_data,
    output logic [ADDR_W-1:0] vga_bram_addr,
    output logic              rd_en,
    output logic [11:0]       rgb,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              blank_out,
    output logic              streaming,
    output logic              frame_done
);

    state_t            state_q;
    logic              frame_done_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [11:0]       rgb_q;

    logic              sof;
    logic              visible;
    logic              last_px;
    logic              active_d;
    logic [ADDR_W-1:0] addr_d;

    assign sof     = (hcount == 10'd0) && (vcount == 10'd0);
    assign visible = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
    assign last_px = (hcount == 10'(H_ACTIVE - 1)) && (vcount == 10'(V_ACTIVE - 1));
    assign addr_d  = pix_addr(hcount, vcount);

    // The SOF strobe that moves WAIT_SOF into STREAM already reads pixel 0,
    // so the first streamed frame is complete.
    assign active_d = visible &&
                      ((state_q == STREAM) ||
                       ((state_q == WAIT_SOF) && vga_start && sof));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pix_en && vga_start) state_q <= WAIT_SOF;
                end
                WAIT_SOF: begin
                    if (!vga_start)         state_q <= IDLE;
                    else if (pix_en && sof) state_q <= STREAM;
                end
                STREAM: begin
                    if (pix_en && last_px) begin
                        frame_done_q <= 1'b1;
                        if (!vga_start) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // rd_en_q doubles as the stage-1 "active" flag seen by the palette stage.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            rgb_q   <= 12'h000;
        end else if (pix_en) begin
            rd_en_q <= active_d;
            if (active_d) addr_q <= addr_d;
            rgb_q   <= rd_en_q ? PALETTE[bin_data] : 12'h000;
        end
    end

    sync_delay_pipe #(
        .DEPTH (2),
        .WIDTH (3)
    ) u_sync_delay_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (pix_en),
        .d       ({hsync_in, vsync_in, blank_in}),
        .q       ({hsync_out, vsync_out, blank_out})
    );

    assign vga_bram_addr = addr_q;
    assign rd_en         = rd_en_q;
    assign rgb           = rgb_q;
    assign streaming     = (state_q == STREAM);
    assign frame_done    = frame_done_q;

endmodule

`default_nettype wire
